// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Optional add/subtract mode is enabled by defining DIGIT_SERIAL_ADDSUB_EN.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_e;

    // The digit counter never drops below one bit, even for a single digit.
    function automatic int dsa_cnt_width(input int width);
        int digits;
        digits = width / 2;
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/dsa_digit_cell.sv
// Combinational 2-bit full adder; the single arithmetic cell of the digit-serial adder.
module dsa_digit_cell (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [2:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {2'b00, cin};
    assign s     = total[1:0];
    assign cout  = total[2];

endmodule

// File: rtl/digit_serial_adder.sv
// Adds two WIDTH-bit operands two bits per clock, least-significant digit first.
// Define DIGIT_SERIAL_ADDSUB_EN to add a 'sub' input selecting a - b.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef DIGIT_SERIAL_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output dsa_state_e       dbg_state
);

    localparam int D  = WIDTH / 2;
    localparam int CW = dsa_cnt_width(WIDTH);

    // Handshake: an add is accepted on a rising edge where start=1 and ready=1.
    // ready is high only in IDLE; done pulses for the single DONE cycle, and
    // sum/co stay stable from then until the next accepted start.

    dsa_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;

    logic             accept;
    logic             last_digit;
    logic [CW:0]      digit_idx;
    logic [1:0]       cell_s;
    logic             cell_cout;
    logic [WIDTH+1:0] sum_shift;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    assign accept     = (state_q == IDLE) && start;
    assign last_digit = (cnt_q == CW'(D - 1));
    assign digit_idx  = {cnt_q, 1'b0};

`ifdef DIGIT_SERIAL_ADDSUB_EN
    // Subtraction is a + ~b + 1; carry-out of 1 then means no borrow.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : ci;
`else
    assign b_load     = b;
    assign carry_load = ci;
`endif

    dsa_digit_cell u_cell (
        .x    (a_q[digit_idx +: 2]),
        .y    (b_q[digit_idx +: 2]),
        .cin  (carry_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // New digits enter at the MSB end so the last digit lands in place.
    assign sum_shift = {cell_s, sum_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE);
        done      = (state_q == DONE);
        sum       = sum_q;
        co        = co_q;
        dbg_state = state_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_d   = sum_shift[WIDTH+1:2];
            carry_d = cell_cout;
            if (last_digit) begin
                co_d = cell_cout;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomised self-checking bench for digit_serial_adder at WIDTH=8 and WIDTH=2.
// Honours DIGIT_SERIAL_ADDSUB_EN to exercise the subtract mode.
module tb_digit_serial_adder;
    import dsa_pkg::*;

`ifdef DIGIT_SERIAL_ADDSUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    logic       start8, ci8, sub8, ready8, done8, co8;
    logic [7:0] a8, b8, sum8;
    dsa_state_e dbg8;

    logic       start2, ci2, sub2, ready2, done2, co2;
    logic [1:0] a2, b2, sum2;
    dsa_state_e dbg2;

    int vectors;
    int miscompares;

    logic [8:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    digit_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .ci        (ci8),
`ifdef DIGIT_SERIAL_ADDSUB_EN
        .sub       (sub8),
`endif
        .ready     (ready8),
        .done      (done8),
        .sum       (sum8),
        .co        (co8),
        .dbg_state (dbg8)
    );

    digit_serial_adder #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .a         (a2),
        .b         (b2),
        .ci        (ci2),
`ifdef DIGIT_SERIAL_ADDSUB_EN
        .sub       (sub2),
`endif
        .ready     (ready2),
        .done      (done2),
        .sum       (sum2),
        .co        (co2),
        .dbg_state (dbg2)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 8) ? ready8 : ready2;
    endfunction

    function automatic logic dn(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    function automatic logic [7:0] sm(input int w);
        return (w == 8) ? sum8 : {6'b0, sum2};
    endfunction

    function automatic logic cy(input int w);
        return (w == 8) ? co8 : co2;
    endfunction

    // Reference: {co, sum} = a + b + ci, or a - b as a + (2^w - 1 - b) + 1.
    function automatic logic [8:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                         input logic civ, input logic subv);
        int mask;
        int total;
        mask = (1 << w) - 1;
        if (SUB_EN && subv) total = (int'(av) & mask) + (mask - (int'(bv) & mask)) + 1;
        else                total = (int'(av) & mask) + (int'(bv) & mask) + int'(civ);
        return {1'(total >> w), 8'(total & mask)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input logic subv);
        if (w == 8) begin
            start8 = s; a8 = av; b8 = bv; ci8 = civ; sub8 = subv;
        end else begin
            start2 = s; a2 = av[1:0]; b2 = bv[1:0]; ci2 = civ; sub2 = subv;
        end
    endtask

    task automatic wait_ready(input int w);
        int n;
        n = 0;
        while (!rdy(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", rdy(w), 1'b1);
    endtask

    // Call and return at a negedge. With noise=1, start is re-asserted with
    // fresh operands on every busy cycle; those requests must be ignored.
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic subv, input bit noise);
        int n;
        logic [8:0] exp;
        wait_ready(w);
        exp_q.push_back(model(w, av, bv, civ, subv));
        drive(w, 1'b1, av, bv, civ, subv);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        n = 1;
        while (!dn(w) && n < 20) begin
            check("busy_ready", rdy(w), 1'b0);
            if (noise) drive(w, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            n++;
        end
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        check("latency", 32'(n), 32'(w / 2 + 1));
        check("done_ready", rdy(w), 1'b0);
        exp = exp_q.pop_front();
        check("sum", sm(w), exp[7:0]);
        check("co", cy(w), exp[8]);
        @(negedge clk);
        check("done_one_pulse", dn(w), 1'b0);
        check("ready_after", rdy(w), 1'b1);
        check("sum_hold", sm(w), exp[7:0]);
        check("co_hold", cy(w), exp[8]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_ready8", ready8, 1'b1);
        check("rst_done8", done8, 1'b0);
        check("rst_sum8", sum8, 8'h00);
        check("rst_co8", co8, 1'b0);
        check("rst_ready2", ready2, 1'b1);
        check("rst_sum2", sum2, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8, 8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0);
        run_op(8, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        run_op(8, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

        // asynchronous reset after digit 1 has been processed
        wait_ready(8);
        drive(8, 1'b1, 8'hA7, 8'h6E, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", ready8, 1'b1);
        check("arst_done", done8, 1'b0);
        check("arst_sum", sum8, 8'h00);
        check("arst_co", co8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            dones += int'(done8);
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run_op(8, 8'hC3, 8'h4D, 1'b1, 1'b0, 1'b0);

        // WIDTH=2 exhaustive
        for (int i = 0; i < 32; i++) begin
            run_op(2, 8'(i & 3), 8'((i >> 2) & 3), 1'(i >> 4), 1'b0, 1'b0);
        end

        if (SUB_EN) begin
            run_op(8, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
            run_op(8, 8'h20, 8'h10, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) begin
                run_op(2, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                       1'($urandom), 1'b1, 1'b0);
            end
        end

        // randomised operations on the 8-bit instance
        for (int i = 0; i < 40; i++) begin
            run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
